vga_frame_scanner: RTL and testbench

//   Pixel-timing source and RGB output stage for the video pipeline. Generates the raster

---
 rtl/vga_frame_scanner_if.sv | 21 ++
 rtl/vga_frame_scanner.sv | 115 +++++++++++
 tb/tb_vga_frame_scanner.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_scanner_if.sv
// Bundle of the signals between the scanner, color_mapper and the VGA pins.
//   master : scanner side (takes RGB in, drives scan position, strobes and pins)
//   slave  : consumer side (color_mapper, motion logic and the board pins)
interface vga_frame_scanner_if;
  logic [7:0] Red_in, Green_in, Blue_in;
  logic [9:0] DrawX, DrawY;
  logic       pix_en, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N;

  modport master (
    input  Red_in, Green_in, Blue_in,
    output DrawX, DrawY, pix_en, frame_start,
           VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );
  modport slave (
    output Red_in, Green_in, Blue_in,
    input  DrawX, DrawY, pix_en, frame_start,
           VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
  );
endinterface

// File: rtl/vga_frame_scanner.sv
// Raster timing generator and registered RGB output stage.
//   Clk, Reset_n : single clock, async active-low reset
//   bus (master) : Red/Green/Blue_in from color_mapper; DrawX/DrawY scan
//                  position; pix_en pixel strobe; frame_start per-frame pulse;
//                  VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N to the pins.
// The output stage lags DrawX/DrawY by one pixel, so color_mapper gets a full
// pixel period to turn the position into a colour.
module vga_frame_scanner #(
  parameter int PIX_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  vga_frame_scanner_if.master  bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       hc_q, hc_d, vc_q, vc_d;
  logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic             fs_q, fs_d;
  logic             vis, h_wrap, v_wrap;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    // pix_en is a flop: it goes high for the cycle in which div reads its last
    // value, which also keeps it low while in reset when PIX_DIV == 1.
    pix_en_d  = (div_d == DIV_LAST);
    h_wrap    = (hc_q == H_LAST);
    v_wrap    = (vc_q == V_LAST);
    vis       = (hc_q < H_VIS) && (vc_q < V_VIS);
    hc_d      = hc_q;
    vc_d      = vc_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    fs_d      = 1'b0;
    if (pix_en_q) begin
      hc_d = h_wrap ? '0 : hc_q + 10'd1;
      if (h_wrap) vc_d = v_wrap ? '0 : vc_q + 10'd1;
      // Output stage uses the pre-increment position: one pixel behind DrawX/Y.
      blank_n_d = vis;
      r_d       = vis ? bus.Red_in   : 8'h00;
      g_d       = vis ? bus.Green_in : 8'h00;
      b_d       = vis ? bus.Blue_in  : 8'h00;
      hs_d      = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
      vs_d      = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
      // Lands in the same cycle the counters first read (0,0).
      fs_d      = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      pix_en_q  <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      pix_en_q  <= pix_en_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.DrawX       = hc_q;
  assign bus.DrawY       = vc_q;
  assign bus.pix_en      = pix_en_q;
  assign bus.frame_start = fs_q;
  assign bus.VGA_R       = r_q;
  assign bus.VGA_G       = g_q;
  assign bus.VGA_B       = b_q;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLANK_N = blank_n_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
module tb_vga_frame_scanner;
  // Shrunken raster so whole frames fit in a short run.
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 8

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  vga_frame_scanner_if bus2 ();
  vga_frame_scanner_if bus1 ();

  vga_frame_scanner #(.PIX_DIV(2), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    u_dut2 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus2));
  vga_frame_scanner #(.PIX_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    u_dut1 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference (index 0: PIX_DIV=2, 1: PIX_DIV=1)
  // State is just "clock edges since release" and "pixels strobed so far";
  // scan position follows from division by the raster dimensions.
  int          mk [2];
  int          mn [2];
  logic [7:0]  er [2], eg [2], eb [2];
  logic        ebl [2], ehs [2], evs [2], efs [2];
  logic [7:0]  rin, gin, bin;

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic exp_pe(input int i);
    return (mk[i] >= 1) && ((mk[i] % div_of(i)) == div_of(i) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; mn[i] = 0;
      er[i] = 0; eg[i] = 0; eb[i] = 0;
      ebl[i] = 0; ehs[i] = 1; evs[i] = 1; efs[i] = 0;
    end
  endtask

  task automatic model_edge();
    int x, y;
    logic v;
    for (int i = 0; i < 2; i++) begin
      x = mn[i] % HT;
      y = (mn[i] / HT) % VT;
      efs[i] = 1'b0;
      if (exp_pe(i)) begin
        v      = (x < HV) && (y < VV);
        ebl[i] = v;
        er[i]  = v ? rin : 8'h00;
        eg[i]  = v ? gin : 8'h00;
        eb[i]  = v ? bin : 8'h00;
        ehs[i] = !((x >= HV + HF) && (x < HV + HF + HS));
        evs[i] = !((y >= VV + VF) && (y < VV + VF + VS));
        efs[i] = (x == HT - 1) && (y == VT - 1);
        mn[i]++;
      end
      mk[i]++;
    end
  endtask

  task automatic cmp(input int i, input logic [9:0] dx, input logic [9:0] dy,
                     input logic pe, input logic fs, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b, input logic hs,
                     input logic vs, input logic bl);
    chk($sformatf("d%0d DrawX", i),  dx, mn[i] % HT);
    chk($sformatf("d%0d DrawY", i),  dy, (mn[i] / HT) % VT);
    chk($sformatf("d%0d pix_en", i), pe, exp_pe(i));
    chk($sformatf("d%0d frame_start", i), fs, efs[i]);
    chk($sformatf("d%0d VGA_R", i),  r, er[i]);
    chk($sformatf("d%0d VGA_G", i),  g, eg[i]);
    chk($sformatf("d%0d VGA_B", i),  b, eb[i]);
    chk($sformatf("d%0d VGA_HS", i), hs, ehs[i]);
    chk($sformatf("d%0d VGA_VS", i), vs, evs[i]);
    chk($sformatf("d%0d VGA_BLANK_N", i), bl, ebl[i]);
  endtask

  task automatic cmp_both();
    cmp(0, bus2.DrawX, bus2.DrawY, bus2.pix_en, bus2.frame_start, bus2.VGA_R,
        bus2.VGA_G, bus2.VGA_B, bus2.VGA_HS, bus2.VGA_VS, bus2.VGA_BLANK_N);
    cmp(1, bus1.DrawX, bus1.DrawY, bus1.pix_en, bus1.frame_start, bus1.VGA_R,
        bus1.VGA_G, bus1.VGA_B, bus1.VGA_HS, bus1.VGA_VS, bus1.VGA_BLANK_N);
  endtask

  task automatic drive_in(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    rin = r; gin = g; bin = b;
    bus2.Red_in = r; bus2.Green_in = g; bus2.Blue_in = b;
    bus1.Red_in = r; bus1.Green_in = g; bus1.Blue_in = b;
  endtask

  // ---------------- directed table for the PIX_DIV=2 build
  typedef struct {
    int         pix;
    logic [7:0] r, g, b;
    logic       bl, hs, vs;
    logic [7:0] er, eg, eb;
  } vec_t;
  vec_t tbl [13];
  int   cur_k;

  task automatic tick();
    @(posedge Clk); #1;
    cur_k++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected done before %0t", $time);
    $fatal(1);
  end

  initial begin
    //           pix  r      g      b      bl  hs  vs  er     eg     eb
    tbl[0]  = '{0,   8'hFF, 8'h55, 8'h00, 1, 1, 1, 8'hFF, 8'h55, 8'h00};
    tbl[1]  = '{7,   8'h12, 8'h34, 8'h56, 1, 1, 1, 8'h12, 8'h34, 8'h56};
    tbl[2]  = '{8,   8'hAA, 8'hBB, 8'hCC, 0, 1, 1, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{10,  8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{12,  8'h11, 8'h22, 8'h33, 0, 0, 1, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{13,  8'h44, 8'h55, 8'h66, 0, 1, 1, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{15,  8'hFF, 8'h55, 8'h00, 1, 1, 1, 8'hFF, 8'h55, 8'h00};
    tbl[7]  = '{52,  8'h9A, 8'hBC, 8'hDE, 1, 1, 1, 8'h9A, 8'hBC, 8'hDE};
    tbl[8]  = '{60,  8'h77, 8'h77, 8'h77, 0, 1, 1, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{75,  8'h88, 8'h88, 8'h88, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{97,  8'h99, 8'h99, 8'h99, 0, 1, 0, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{100, 8'h5A, 8'h5A, 8'h5A, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{119, 8'hC3, 8'hC3, 8'hC3, 0, 1, 1, 8'h00, 8'h00, 8'h00};

    Reset_n = 1'b0;
    drive_in(8'h00, 8'h00, 8'h00);
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    cmp_both();                       // reset values on both builds
    Reset_n = 1'b1;
    cur_k = 0;

    // Pixel p is strobed in the cycle after 2p+1 edges; its output shows after 2p+2.
    foreach (tbl[v]) begin
      while (cur_k < 2 * tbl[v].pix + 1) tick();
      drive_in(tbl[v].r, tbl[v].g, tbl[v].b);
      tick();
      // Scramble inputs between strobes; the registered pixel must not follow them.
      drive_in(8'h3C, 8'hC3, 8'h81);
      chk($sformatf("tbl%0d VGA_BLANK_N", v), bus2.VGA_BLANK_N, tbl[v].bl);
      chk($sformatf("tbl%0d VGA_HS", v), bus2.VGA_HS, tbl[v].hs);
      chk($sformatf("tbl%0d VGA_VS", v), bus2.VGA_VS, tbl[v].vs);
      chk($sformatf("tbl%0d VGA_R", v), bus2.VGA_R, tbl[v].er);
      chk($sformatf("tbl%0d VGA_G", v), bus2.VGA_G, tbl[v].eg);
      chk($sformatf("tbl%0d VGA_B", v), bus2.VGA_B, tbl[v].eb);
    end
    // Last pixel of the frame was just strobed: wrap to (0,0) with frame_start.
    chk("wrap frame_start", bus2.frame_start, 1);
    chk("wrap DrawX", bus2.DrawX, 0);
    chk("wrap DrawY", bus2.DrawY, 0);
    tick();
    chk("wrap frame_start one cycle", bus2.frame_start, 0);
    chk("wrap pix_en", bus2.pix_en, 1);
    chk("wrap DrawX hold", bus2.DrawX, 0);

    // ---------------- randomized run against the reference model
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cmp_both();
      if (cyc == 437) begin
        // Async reset mid-cycle, mid-frame: outputs must clear before the next edge.
        Reset_n = 1'b0;
        #2;
        model_reset();
        cmp_both();
        @(posedge Clk); #1;
        cmp_both();
        Reset_n = 1'b1;
      end else begin
        drive_in(8'($urandom), 8'($urandom), 8'($urandom));
        model_edge();
        @(posedge Clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
